rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//  4-requester round-robin arbiter with hold-timeout. Grants one shared resource
//  (e.g. one binary-to-BCD converter) to one of four requesters.
//  Drives a one-hot grant vector plus its 2-bit encoded index, so the selected
//  requester's data can be muxed straight into the shared datapath.
//  A fair rotating pointer prevents starvation. A hold counter revokes any grant
//  held longer than MAX_HOLD cycles.
// PARAMETERS
//  MAX_HOLD  15  max consecutive cycles one grant may be held (>=1, <=255)
//  CNT_W     8   width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk          in   1  single clock, all logic on rising edge
//  reset        in   1  synchronous, active-high
//  req          in   4  request per requester; holder keeps high while using resource
//  grant        out  4  one-hot grant, registered; 4'b0000 when idle
//  grant_idx    out  2  binary index of grant (0001->0,0010->1,0100->2,1000->3); 0 when idle
//  grant_valid  out  1  1 when grant != 0
//  timeout      out  1  one-cycle pulse when a grant is revoked by the hold limit
// BEHAVIOUR
//  Reset: grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0, hold_cnt=0,
//   state=IDLE. Reset is sampled on clk edge and overrides everything, including mid-grant.
//  Pointer ptr (2b): highest-priority requester. Search order is ptr, ptr+1, ptr+2,
//   ptr+3, all mod 4. On every new grant to index k, ptr <= (k+1) mod 4.
//  States:
//   IDLE: if |req, grant the first requester in search order at the next edge
//    (latency 1 cycle from req to grant), hold_cnt<=0, go to GRANT.
//    Otherwise stay in IDLE.
//   GRANT, holder g:
//    - Release: if req[g]==0, arbitrate among current req the same edge.
//      With a winner, go directly to the new grant (no bubble cycle).
//      With no requester, grant<=0 and go to IDLE.
//    - Timeout: if req[g]==1 and hold_cnt==MAX_HOLD-1, timeout<=1 for one cycle.
//      Arbitrate with g masked out. If no other requester, re-grant g with
//      hold_cnt<=0; g is never left ungranted while requesting.
//    - Otherwise: hold_cnt<=hold_cnt+1 and grant unchanged.
//  grant_idx and grant_valid are registered alongside grant. They are always
//   consistent with grant in the same cycle.
//  At most one grant bit is set in any cycle. A new request never preempts a
//   valid holder before release or timeout.
//  Requests asserted in the same cycle are resolved purely by ptr order.
//  No other tie-break exists.
//  Wrap-around: ptr 3 -> 0. hold_cnt never exceeds MAX_HOLD-1.
// TESTING
//  1. Reset: assert reset 2 cycles with req=4'b1111 -> grant=0, grant_idx=0,
//     grant_valid=0, timeout=0. Release reset -> next edge grant=0001, idx=0.
//  2. Round robin: req=1111 held. Each holder drops its req 3 cycles after its
//     grant, then reasserts -> grant order 0001,0010,0100,1000,0001.
//     No idle cycle between grants.
//  3. Timeout: MAX_HOLD=4, req=0011 held steady -> req1 granted after 4 cycles,
//     timeout pulses one cycle at each handover. Then req=0001 only ->
//     req0 is re-granted in place at each timeout.
//  4. Idle/latency: req=0 for 5 cycles, then req=0100 -> grant=0100, idx=2
//     exactly 1 cycle later. Drop req -> grant=0 next cycle, state IDLE.
//  5. Wrap/simultaneous: ptr=3 (after granting req2), req=1001 -> grant=1000.
//     On its release with req=0001 -> grant=0001.
//  6. Mid-op reset: reset asserted during a grant with hold_cnt=2 -> all outputs
//     0 next edge. Afterwards ptr=0, so req=1010 -> grant=0010.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-way round-robin arbiter with hold-timeout revocation
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [1:0] ptr, ptr_n, win_idx, off, idx_n;
  logic [3:0] cand, rot, grant_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic win_ok, held, expire, timeout_n;
  // the holder is masked out of arbitration only when its hold limit expires
  always_comb begin
    held   = state == GRANT && req[grant_idx];
    expire = held && hold_cnt == CNT_W'(MAX_HOLD - 1);
    cand   = expire ? req & ~grant : req;
    for (int i = 0; i < 4; i++) rot[i] = cand[2'(ptr + 2'(i))];
    off     = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win_ok  = |cand;
    win_idx = ptr + off;
  end
  // next-state: keep, hand over, re-grant in place on a lone timeout, or go idle
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    idx_n     = grant_idx;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    timeout_n = 1'b0;
    if (held && !expire) begin
      hold_n = hold_cnt + CNT_W'(1);
    end else if (win_ok) begin
      state_n   = GRANT;
      grant_n   = 4'b0001 << win_idx;
      idx_n     = win_idx;
      ptr_n     = win_idx + 2'd1;
      hold_n    = '0;
      timeout_n = expire;
    end else if (expire) begin
      hold_n    = '0;
      timeout_n = 1'b1;
    end else begin
      state_n = IDLE;
      grant_n = 4'b0000;
      idx_n   = 2'd0;
      hold_n  = '0;
    end
  end
  // registered outputs and arbitration state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      ptr         <= 2'd0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      grant_valid <= |grant_n;
      timeout     <= timeout_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: random and directed checks of rr_arbiter_4 against a behavioural model
module tb_rr_arbiter_4;
  localparam int MH = 4;
  logic clk = 0, reset = 1;
  logic [3:0] req = 4'b1111;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic grant_valid, timeout;
  int total = 0, bad = 0;
  int m_hold = -1, m_ptr = 0, m_cnt = 0, w;
  bit m_to = 0, started = 0;
  logic [3:0] r, e;

  rr_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .grant(grant),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] q, input int p);
    for (int i = 0; i < 4; i++) if (q[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // model: holder index (-1 idle), cycles held so far, rotating priority start
  always @(posedge clk) begin
    if (reset) begin
      m_hold = -1; m_ptr = 0; m_cnt = 0; m_to = 0; started = 1;
    end else begin
      r = req; m_to = 0; w = -2;
      if (m_hold < 0) w = pick(r, m_ptr);
      else if (!r[m_hold]) w = pick(r, m_ptr);
      else if (m_cnt == MH) begin
        m_to = 1; r[m_hold] = 1'b0; w = pick(r, m_ptr);
        if (w < 0) w = m_hold;
      end
      if (w == -2) m_cnt++;
      else begin
        m_hold = w; m_cnt = 1;
        if (w >= 0) m_ptr = (w + 1) % 4;
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("m_grant", {4'd0, grant}, m_hold < 0 ? 8'd0 : 8'(1 << m_hold));
    chk("m_idx", {6'd0, grant_idx}, m_hold < 0 ? 8'd0 : 8'(m_hold));
    chk("m_valid", {7'd0, grant_valid}, {7'd0, m_hold >= 0});
    chk("m_timeout", {7'd0, timeout}, {7'd0, m_to});
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("rst_grant", {4'd0, grant}, 8'h00);
    chk("rst_idx", {6'd0, grant_idx}, 8'h00);
    chk("rst_valid", {7'd0, grant_valid}, 8'h00);
    chk("rst_timeout", {7'd0, timeout}, 8'h00);
    @(negedge clk) reset = 0;
    @(negedge clk);
    #1 chk("first_grant", {4'd0, grant}, 8'h01);
    e = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      req = ~e;
      e = {e[2:0], e[3]};
      @(negedge clk) req = 4'b1111;
      #1 chk("rr_order", {4'd0, grant}, {4'd0, e});
    end
    req = 4'b0011;
    repeat (3) @(negedge clk);
    #1 chk("to_hold", {4'd0, grant}, 8'h01);
    @(negedge clk);
    #1 chk("to_handover", {4'd0, grant}, 8'h02);
    chk("to_pulse", {7'd0, timeout}, 8'h01);
    @(negedge clk) req = 4'b0001;
    #1 chk("to_pulse_end", {7'd0, timeout}, 8'h00);
    @(negedge clk);
    #1 chk("release_to0", {4'd0, grant}, 8'h01);
    repeat (4) @(negedge clk);
    #1 chk("regrant_in_place", {4'd0, grant}, 8'h01);
    chk("regrant_pulse", {7'd0, timeout}, 8'h01);
    req = 4'b0000;
    repeat (5) @(negedge clk);
    #1 chk("idle", {7'd0, grant_valid}, 8'h00);
    req = 4'b0100;
    @(negedge clk);
    #1 chk("latency_grant", {4'd0, grant}, 8'h04);
    chk("latency_idx", {6'd0, grant_idx}, 8'h02);
    req = 4'b0000;
    @(negedge clk);
    #1 chk("drop_idle", {4'd0, grant}, 8'h00);
    req = 4'b1001;
    @(negedge clk);
    #1 chk("wrap_grant", {4'd0, grant}, 8'h08);
    req = 4'b0001;
    @(negedge clk);
    #1 chk("wrap_release", {4'd0, grant}, 8'h01);
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    #1 chk("midrst_grant", {4'd0, grant}, 8'h00);
    chk("midrst_timeout", {7'd0, timeout}, 8'h00);
    reset = 0; req = 4'b1010;
    @(negedge clk);
    #1 chk("post_rst_ptr", {4'd0, grant}, 8'h02);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      reset = $urandom_range(0, 299) == 0;
    end
    reset = 0;
    @(negedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
